// File: rtl/shifter_pkg.sv
// shifter_pkg: shared state encoding and clamp helper for the serial right shifter
package shifter_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} shift_state_t;
  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction
endpackage

// File: rtl/right_shift_step.sv
// right_shift_step: combinational right shift by k (0..STEP) with a fill bit at the MSB end
module right_shift_step #(
  parameter int N = 8,
  parameter int STEP = 2,
  localparam int KW = $clog2(STEP + 1)
) (
  input  logic [N-1:0]  a,
  input  logic [KW-1:0] k,
  input  logic          fill,
  output logic [N-1:0]  y
);
  assign y = (a >> k) | (fill ? ~({N{1'b1}} >> k) : '0);
endmodule

// File: rtl/serial_right_shifter.sv
// serial_right_shifter: multi-cycle variable right shifter, at most STEP bits per cycle,
// valid/ready on both sides, logical or arithmetic fill.
module serial_right_shifter
  import shifter_pkg::*;
#(
  parameter int N = 8,
  parameter int STEP = 2,
  localparam int SW = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [N-1:0]  up_data,
  input  logic [SW-1:0] up_shamt,
  input  logic          up_arith,
  output logic          down_valid,
  input  logic          down_ready,
  output logic [N-1:0]  down_data
);
  localparam int KW = $clog2(STEP + 1);
  localparam logic [SW-1:0] STEP_W = SW'(STEP);
  shift_state_t state, state_n;
  logic [N-1:0] data, shifted;
  logic [SW-1:0] rem;
  logic [KW-1:0] k;
  logic fill, last;
  assign k = KW'(min_u(32'(rem), STEP));
  assign last = rem <= STEP_W;
  right_shift_step #(.N(N), .STEP(STEP)) u_step (.a(data), .k(k), .fill(fill), .y(shifted));
  always_comb begin
    state_n = state;
    up_ready = state == IDLE;
    down_valid = state == DONE;
    case (state)
      IDLE:    state_n = up_valid ? SHIFT : IDLE;
      SHIFT:   state_n = last ? DONE : SHIFT;
      DONE:    state_n = down_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      data <= '0;
      fill <= 1'b0;
      rem <= '0;
      down_data <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && up_valid) begin
        data <= up_data;
        fill <= up_arith & up_data[N-1];
        rem <= SW'(min_u(32'(up_shamt), N));
      end
      if (state == SHIFT) begin
        data <= shifted;
        rem <= rem - SW'(k);
        // down_data only moves on the final step so it keeps the last result meanwhile
        if (last) down_data <= shifted;
      end
    end
  end
endmodule

// File: tb/tb_serial_right_shifter.sv
// tb_serial_right_shifter: scoreboard bench over STEP = 2, 1 and N with directed and random requests
module tb_serial_right_shifter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int errs = 0;
  int checks = 0;
  int ndone = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {
    logic [7:0] d;
    int acc;
    int lat;
  } exp_t;
  function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [3:0] s, input logic a);
    return a ? 8'($signed(d) >>> s) : 8'(d >> s);
  endfunction
  task automatic chk(input int cfg, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL cfg%0d %s: got %0h expected %0h", cfg, name, act, exp);
    end
  endtask
  genvar g;
  for (g = 0; g < 3; g++) begin : cfg
    localparam int ST = (g == 0) ? 2 : (g == 1) ? 1 : 8;
    logic rst = 1'b1, up_valid = 1'b0, up_arith = 1'b0, down_ready = 1'b0, stall = 1'b0;
    logic up_ready, down_valid;
    logic [7:0] up_data = '0;
    logic [7:0] down_data, held;
    logic [3:0] up_shamt = '0;
    exp_t q[$];
    bit pend = 1'b0;
    serial_right_shifter #(.N(8), .STEP(ST)) dut (
      .clk(clk), .rst(rst), .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data),
      .up_shamt(up_shamt), .up_arith(up_arith), .down_valid(down_valid),
      .down_ready(down_ready), .down_data(down_data)
    );
    function automatic int lat_of(input logic [3:0] s);
      int m;
      m = (s > 8) ? 8 : int'(s);
      return (m == 0) ? 1 : (m + ST - 1) / ST;
    endfunction
    task automatic send(input logic [7:0] d, input logic [3:0] s, input logic a, input logic [7:0] e);
      int t;
      t = 0;
      up_data = d;
      up_shamt = s;
      up_arith = a;
      up_valid = 1'b1;
      while (!up_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (!up_ready) chk(g, "accept_timeout", 32'(up_ready), 32'd1);
      else q.push_back('{e, cyc + 1, lat_of(s)});
      @(negedge clk);
      up_valid = 1'b0;
    endtask
    task automatic drain();
      int t;
      t = 0;
      while (q.size() > 0 && t < 400) begin
        @(negedge clk);
        t++;
      end
      chk(g, "drain", 32'(q.size()), 32'd0);
    endtask
    initial forever begin
      @(negedge clk);
      if (down_valid) begin
        if (q.size() == 0) chk(g, "unexpected_output", 32'(down_valid), 32'd0);
        else begin
          if (!pend) begin
            pend = 1'b1;
            held = down_data;
            chk(g, "latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
          end
          chk(g, "hold_stable", 32'(down_data), 32'(held));
        end
      end
      down_ready = stall ? 1'b0 : ($urandom_range(3) != 0);
      if (down_valid && down_ready && q.size() > 0) begin
        chk(g, "data", 32'(down_data), 32'(q[0].d));
        q.pop_front();
        pend = 1'b0;
      end
    end
    initial begin : drive
      logic [7:0] d;
      logic [3:0] s;
      logic a;
      int t;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk(g, "reset_up_ready", 32'(up_ready), 32'd1);
      chk(g, "reset_down_valid", 32'(down_valid), 32'd0);
      chk(g, "reset_down_data", 32'(down_data), 32'd0);
      send(8'hB4, 4'd3, 1'b0, 8'h16);
      send(8'hB4, 4'd3, 1'b1, 8'hF6);
      send(8'h5A, 4'd0, 1'b0, 8'h5A);
      send(8'h80, 4'd9, 1'b1, 8'hFF);
      send(8'h80, 4'd9, 1'b0, 8'h00);
      send(8'h7F, 4'd8, 1'b1, 8'h00);
      drain();
      // hold the result under backpressure while a second request waits
      stall = 1'b1;
      send(8'hC3, 4'd2, 1'b1, 8'hF0);
      t = 0;
      while (!down_valid && t < 50) begin
        @(negedge clk);
        t++;
      end
      chk(g, "bp_valid", 32'(down_valid), 32'd1);
      up_data = 8'h3C;
      up_shamt = 4'd1;
      up_arith = 1'b0;
      up_valid = 1'b1;
      repeat (5) begin
        @(negedge clk);
        chk(g, "bp_hold_valid", 32'(down_valid), 32'd1);
        chk(g, "bp_up_ready", 32'(up_ready), 32'd0);
      end
      stall = 1'b0;
      send(8'h3C, 4'd1, 1'b0, 8'h1E);
      drain();
      // abort mid-shift: nothing may come out for this request
      send(8'hA5, 4'd15, 1'b1, 8'hFF);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      void'(q.pop_back());
      pend = 1'b0;
      chk(g, "abort_up_ready", 32'(up_ready), 32'd1);
      chk(g, "abort_down_valid", 32'(down_valid), 32'd0);
      repeat (60) begin
        repeat ($urandom_range(2)) @(negedge clk);
        d = 8'($urandom);
        s = 4'($urandom);
        a = 1'($urandom);
        send(d, s, a, ref_shift(d, s, a));
      end
      drain();
      ndone++;
    end
  end
  initial begin
    wait (ndone == 3);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
